freq_meter: RTL
===============

Name: freq_meter

Overview:
- Measures an external slow periodic signal, such as the output of the team's clock divider or a button/board clock, in units of `clk` cycles.
- It is the measuring counterpart to the frequency divider: the divider generates a slow clock from `clk`, and this block recovers the period and high-time of a slow clock relative to `clk`.
- Results feed the display and self-check logic, with a one-cycle valid strobe per completed period.

Parameters:
- CNT_W, 32: width of the period and high-time counters and outputs.
- SYNC_STAGES, 2: number of synchronizer flops on `sig_in` (minimum 2).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous, active-low; clears all state and outputs immediately.
- sig_in  input  1  signal under measurement, asynchronous to `clk`.
- enable  input  1  1 = measure, 0 = idle.
- period  output  CNT_W  `clk` cycles between the last two rising edges of `sig_in`.
- high_cycles  output  CNT_W  `clk` cycles `sig_in` was high within that period.
- valid  output  1  one-cycle pulse when `period`/`high_cycles` update.
- timeout  output  1  sticky flag: the period counter saturated with no rising edge.

Behaviour:

Reset (`rst`=0):
- `period`=0, `high_cycles`=0, `valid`=0, `timeout`=0.
- Synchronizer flops and the previous-sample flop are 0.
- State = IDLE; internal counters are 0.

Synchronizer and edge detect:
- `sig_s` is the last of SYNC_STAGES flops; `prev` is `sig_s` delayed by one cycle.
- `rise` = `sig_s` & ~`prev`.
- A `sig_in` edge captured at clk edge k produces `rise` in the cycle after edge k+SYNC_STAGES-1.

States:
- IDLE:
  - `per_cnt` and `hi_cnt` are held at 0.
  - `enable`=1 → ARM on the next cycle.
- ARM:
  - Waits for the first `rise`.
  - On `rise`: `per_cnt`<=1, `hi_cnt`<=1, go to MEASURE. No `valid`.
  - `enable`=0 → IDLE.
- MEASURE, cycle without `rise`:
  - `per_cnt`<=`per_cnt`+1.
  - `hi_cnt`<=`hi_cnt`+`sig_s`.
- MEASURE, cycle with `rise`:
  - `period`<=`per_cnt`, `high_cycles`<=`hi_cnt`, `valid`<=1 for exactly one cycle, `timeout`<=0.
  - `per_cnt`<=1, `hi_cnt`<=1; stay in MEASURE.
- Resulting values for a square wave of P cycles with H high cycles: `period`=P, `high_cycles`=H. `valid` is registered and asserts the cycle after `rise`.

Saturation:
- If `per_cnt` = all-ones and there is no `rise` that cycle: `timeout`<=1, no `valid`, counters clear to 0, state → ARM.
- `period` and `high_cycles` hold their previous values.
- Simultaneous `rise` and saturation: `rise` wins and a normal measurement completes.

Enable handling:
- `enable`=0 in any state → IDLE on the next cycle, with no `valid`.
- `period`, `high_cycles` and `timeout` hold their values.
- On re-enable, the next measurement requires a fresh ARM: the first rising edge after re-enable produces no `valid`.

Flag and range rules:
- `timeout` clears only on reset or on the next `valid`.
- `hi_cnt` never exceeds `per_cnt`; no separate saturation handling is needed for it.
- Minimum measurable period is 2 `clk` cycles. Faster `sig_in` is out of spec; the result is undefined, but the block must not hang.

Reset mid-operation:
- Asynchronous assert of `rst` returns everything to its reset values within the same cycle.
- Measurement restarts from IDLE after `rst` is released.

Test Plan:
1. Reset and idle: `rst`=0 → all outputs 0 with no clock edge needed. Release `rst` with `enable`=0 and `sig_in` toggling every 10 cycles for 200 cycles → `valid` never asserts.
2. Basic measure: `enable`=1, `sig_in` period 100 cycles, high 50 → no `valid` on the first rise. First `valid` comes one cycle after the second synchronized rise, with `period`=100, `high_cycles`=50. `valid` then repeats every 100 cycles and is exactly 1 cycle wide.
3. Duty/period change: switch to period 10, high 3 → the first full new period reports 10/3; the transitional period reports the true mixed count. Also check period 2, high 1 → reports 2/1.
4. Timeout (CNT_W=8): one rise, then `sig_in` held low → `timeout`=1 once the counter saturates at 255, no `valid`, `period` unchanged. Then apply a 20-cycle square wave → after ARM plus one full period, `valid` with `period`=20 and `timeout`=0.
5. Enable drop: deassert `enable` mid-period → no `valid`, outputs hold. Re-enable → the first rise gives no `valid`; the next rise gives the correct period.
6. Async reset mid-measure: assert `rst` between clock edges during MEASURE → outputs go to 0 immediately. After release with `enable`=1, the first `valid` appears only after two rises.

Source files
------------

// File: rtl/freq_meter.sv
// ---------------------------------------------------------------------------
// freq_meter
//
// Measures a slow periodic signal in units of clk cycles. It reports the
// number of clk cycles between the last two rising edges of sig_in (period)
// and how many of those cycles sig_in was high (high_cycles). valid strobes
// for one cycle whenever a new result is published. timeout is a sticky flag
// that is raised when the period counter saturates without seeing an edge.
//
// Ports:
//   clk          system clock, all logic on its rising edge
//   rst          asynchronous active-low reset, clears all state and outputs
//   sig_in       signal under measurement, asynchronous to clk
//   enable       1 = measure, 0 = idle (results and flag are held)
//   period       clk cycles between the last two rising edges of sig_in
//   high_cycles  clk cycles sig_in was high within that period
//   valid        one-cycle pulse when period/high_cycles update
//   timeout      sticky: period counter saturated with no rising edge;
//                cleared by reset or by the next valid
//
// SYNC_STAGES must be at least 2.
// ---------------------------------------------------------------------------
module freq_meter #(
    parameter int CNT_W       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             enable,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cycles,
    output logic             valid,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;
    logic                   sig_s;
    logic                   rise_s;

    state_t                 state_r;
    state_t                 state_nx_s;
    logic [CNT_W-1:0]       per_cnt_r;
    logic [CNT_W-1:0]       hi_cnt_r;
    logic [CNT_W-1:0]       per_nx_s;
    logic [CNT_W-1:0]       hi_nx_s;
    logic                   capture_s;
    logic                   saturate_s;

    logic [CNT_W-1:0]       period_r;
    logic [CNT_W-1:0]       high_r;
    logic                   valid_r;
    logic                   timeout_r;

    // The last synchronizer stage is the clean sample; prev_r lags it by one.
    assign sig_s  = sync_r[SYNC_STAGES-1];
    assign rise_s = sig_s & ~prev_r;

    // Synchronizer chain and previous-sample flop for edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], sig_in};
            prev_r <= sig_s;
        end
    end

    // Next-state and counter update; enable low has priority over everything,
    // and a rising edge wins over saturation in the same cycle.
    always_comb begin
        state_nx_s = state_r;
        per_nx_s   = per_cnt_r;
        hi_nx_s    = hi_cnt_r;
        capture_s  = 1'b0;
        saturate_s = 1'b0;
        case (state_r)
            IDLE: begin
                per_nx_s = CNT_ZERO;
                hi_nx_s  = CNT_ZERO;
                if (enable) begin
                    state_nx_s = ARM;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ARM: begin
                if (!enable) begin
                    state_nx_s = IDLE;
                    per_nx_s   = CNT_ZERO;
                    hi_nx_s    = CNT_ZERO;
                end else if (rise_s) begin
                    // The rise cycle itself is the first (high) cycle counted.
                    state_nx_s = MEASURE;
                    per_nx_s   = CNT_ONE;
                    hi_nx_s    = CNT_ONE;
                end else begin
                    per_nx_s = CNT_ZERO;
                    hi_nx_s  = CNT_ZERO;
                end
            end
            MEASURE: begin
                if (!enable) begin
                    state_nx_s = IDLE;
                    per_nx_s   = CNT_ZERO;
                    hi_nx_s    = CNT_ZERO;
                end else if (rise_s) begin
                    capture_s = 1'b1;
                    per_nx_s  = CNT_ONE;
                    hi_nx_s   = CNT_ONE;
                end else if (per_cnt_r == CNT_MAX) begin
                    // No edge within the counter range: restart from ARM.
                    saturate_s = 1'b1;
                    state_nx_s = ARM;
                    per_nx_s   = CNT_ZERO;
                    hi_nx_s    = CNT_ZERO;
                end else begin
                    // hi_cnt_r can never pass per_cnt_r, so it needs no clamp.
                    per_nx_s = per_cnt_r + CNT_ONE;
                    hi_nx_s  = hi_cnt_r + {{(CNT_W-1){1'b0}}, sig_s};
                end
            end
            default: begin
                state_nx_s = IDLE;
                per_nx_s   = CNT_ZERO;
                hi_nx_s    = CNT_ZERO;
            end
        endcase
    end

    // State and measurement counter registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            per_cnt_r <= CNT_ZERO;
            hi_cnt_r  <= CNT_ZERO;
        end else begin
            state_r   <= state_nx_s;
            per_cnt_r <= per_nx_s;
            hi_cnt_r  <= hi_nx_s;
        end
    end

    // Registered results, valid strobe and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_r  <= CNT_ZERO;
            high_r    <= CNT_ZERO;
            valid_r   <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            valid_r <= capture_s;
            if (capture_s) begin
                period_r  <= per_cnt_r;
                high_r    <= hi_cnt_r;
                timeout_r <= 1'b0;
            end else if (saturate_s) begin
                timeout_r <= 1'b1;
            end else begin
                timeout_r <= timeout_r;
            end
        end
    end

    assign period      = period_r;
    assign high_cycles = high_r;
    assign valid       = valid_r;
    assign timeout     = timeout_r;

endmodule
